// File: rtl/pf_arb_pkg.sv
// Shared types and defaults for the playfield RAM arbiter.
// Video fetch and CPU access share four async-read pf_ram banks.
package pf_arb_pkg;
  localparam int DEF_ADDR_W       = 10;
  localparam int DEF_BANK_W       = DEF_ADDR_W - 8;
  localparam int DEF_BANKS        = 1 << DEF_BANK_W;
  localparam int DEF_CPU_MAX_WAIT = 3;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    VSETUP = 3'd1,
    VLATCH = 3'd2,
    CSETUP = 3'd3,
    CRD    = 3'd4,
    CWR    = 3'd5
  } state_e;
endpackage

// File: rtl/pf_arb_bank_dec.sv
// Bank index to active-low one-hot chip enables.
// All enables stay high when en is low.
module pf_arb_bank_dec
  import pf_arb_pkg::*;
#(
  parameter int BANKS  = DEF_BANKS,
  parameter int BANK_W = DEF_BANK_W
) (
  input  logic [BANK_W-1:0] bank,
  input  logic              en,
  output logic [BANKS-1:0]  ce_n
);
  always_comb begin
    ce_n = '1;
    for (int i = 0; i < BANKS; i++) begin
      if (en && (bank == BANK_W'(i))) begin
        ce_n[i] = 1'b0;
      end
    end
  end
endmodule

// File: rtl/pf_ram_arb.sv
// Playfield RAM arbiter: video fetch has priority, CPU waits
// a bounded number of cycles and is held off through cpu_ack.
module pf_ram_arb
  import pf_arb_pkg::*;
#(
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int BANKS        = 2 ** (ADDR_W - 8),
  parameter int CPU_MAX_WAIT = DEF_CPU_MAX_WAIT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic [7:0]        vid_data,
  output logic              vid_valid,
  output logic              vid_ovr,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [7:0]        cpu_din,
  output logic [7:0]        cpu_dout,
  output logic              cpu_ack,
  output logic [7:0]        ram_a,
  output logic [7:0]        ram_din,
  input  logic [7:0]        ram_dout,
  output logic [BANKS-1:0]  ram_ce_n,
  output logic              ram_we_n
);
  localparam int BW = ADDR_W - 8;
  localparam int WW = $clog2(CPU_MAX_WAIT + 1);
  localparam logic [WW-1:0] WMAX = WW'(CPU_MAX_WAIT);

  state_e state_q, state_d;
  logic              vid_pend_q, vid_pend_d;
  logic [ADDR_W-1:0] vid_addr_q, vid_addr_d;
  logic              vid_ovr_q, vid_ovr_d;
  logic [WW-1:0]     cpu_wait_q, cpu_wait_d;
  logic [7:0]        ram_a_q, ram_a_d;
  logic [7:0]        ram_din_q, ram_din_d;
  logic [BW-1:0]     bank_q, bank_d;
  logic [7:0]        vid_data_q, vid_data_d;
  logic              vid_valid_q, vid_valid_d;
  logic [7:0]        cpu_dout_q, cpu_dout_d;
  logic              cpu_ack_q, cpu_ack_d;
  logic              starved, grant, vid_go;
  logic              cpu_busy, acc_en;

  assign starved = cpu_req && (cpu_wait_q == WMAX);

  // An incoming vid_req holds IDLE one cycle so video wins a tie.
  always_comb begin : next_state
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (starved)                   state_d = CSETUP;
        else if (vid_pend_q)           state_d = VSETUP;
        else if (cpu_req && !vid_req)  state_d = CSETUP;
        else                           state_d = IDLE;
      end
      VSETUP:  state_d = VLATCH;
      VLATCH:  state_d = IDLE;
      CSETUP:  state_d = cpu_we ? CWR : CRD;
      CRD:     state_d = IDLE;
      CWR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin : datapath
    grant    = (state_q == IDLE) && (state_d == CSETUP);
    vid_go   = (state_q == IDLE) && (state_d == VSETUP);
    cpu_busy = (state_q == CSETUP) || (state_q == CRD)
            || (state_q == CWR);

    vid_pend_d = vid_pend_q;
    if (vid_req)     vid_pend_d = 1'b1;
    else if (vid_go) vid_pend_d = 1'b0;
    vid_addr_d = vid_req ? vid_addr : vid_addr_q;
    vid_ovr_d  = vid_ovr_q | (vid_req & vid_pend_q);

    cpu_wait_d = cpu_wait_q;
    if (!cpu_req || grant || cpu_busy) cpu_wait_d = '0;
    else if (cpu_wait_q != WMAX)       cpu_wait_d = cpu_wait_q + WW'(1);

    ram_a_d   = ram_a_q;
    ram_din_d = ram_din_q;
    bank_d    = bank_q;
    if (vid_go) begin
      ram_a_d = vid_addr_q[7:0];
      bank_d  = vid_addr_q[ADDR_W-1:8];
    end else if (grant) begin
      ram_a_d   = cpu_addr[7:0];
      bank_d    = cpu_addr[ADDR_W-1:8];
      ram_din_d = cpu_din;
    end

    vid_valid_d = (state_q == VLATCH);
    vid_data_d  = (state_q == VLATCH) ? ram_dout : vid_data_q;
    cpu_ack_d   = (state_q == CRD) || (state_q == CWR);
    cpu_dout_d  = (state_q == CRD) ? ram_dout : cpu_dout_q;
  end

  always_comb begin : strobes
    acc_en   = (state_q != IDLE);
    ram_we_n = (state_q != CWR);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      vid_pend_q  <= 1'b0;
      vid_addr_q  <= '0;
      vid_ovr_q   <= 1'b0;
      cpu_wait_q  <= '0;
      ram_a_q     <= '0;
      ram_din_q   <= '0;
      bank_q      <= '0;
      vid_data_q  <= '0;
      vid_valid_q <= 1'b0;
      cpu_dout_q  <= '0;
      cpu_ack_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      vid_pend_q  <= vid_pend_d;
      vid_addr_q  <= vid_addr_d;
      vid_ovr_q   <= vid_ovr_d;
      cpu_wait_q  <= cpu_wait_d;
      ram_a_q     <= ram_a_d;
      ram_din_q   <= ram_din_d;
      bank_q      <= bank_d;
      vid_data_q  <= vid_data_d;
      vid_valid_q <= vid_valid_d;
      cpu_dout_q  <= cpu_dout_d;
      cpu_ack_q   <= cpu_ack_d;
    end
  end

  pf_arb_bank_dec #(
    .BANKS  (BANKS),
    .BANK_W (BW)
  ) u_dec (
    .bank (bank_q),
    .en   (acc_en),
    .ce_n (ram_ce_n)
  );

  assign ram_a     = ram_a_q;
  assign ram_din   = ram_din_q;
  assign vid_data  = vid_data_q;
  assign vid_valid = vid_valid_q;
  assign vid_ovr   = vid_ovr_q;
  assign cpu_dout  = cpu_dout_q;
  assign cpu_ack   = cpu_ack_q;
endmodule
